// File: rtl/move_register.sv
// Writer side of the tic-tac-toe occupancy vectors: takes one cell per move,
// alternates turns and refuses moves into occupied or out-of-range cells.
module move_register #(
  parameter int FIRST_PLAYER = 0,
  parameter int LOCK_ON_FULL = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       game_over,
  input  logic       move_valid,
  input  logic [3:0] move_pos,
  output logic       move_ready,
  output logic       move_accept,
  output logic       move_reject,
  output logic [0:8] p1,
  output logic [0:8] p2,
  output logic       turn,
  output logic [3:0] move_count,
  output logic       board_full
);

  typedef enum logic [1:0] {
    P1_TURN = 2'd0,
    P2_TURN = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic   FIRST_TURN  = (FIRST_PLAYER != 0) ? 1'b1 : 1'b0;
  localparam state_t FIRST_STATE = (FIRST_PLAYER != 0) ? P2_TURN : P1_TURN;
  localparam logic   LOCK_FULL   = (LOCK_ON_FULL != 0) ? 1'b1 : 1'b0;

  state_t     r_state;
  logic       r_ready;
  logic       r_accept;
  logic       r_reject;
  logic [0:8] r_p1;
  logic [0:8] r_p2;
  logic       r_turn;
  logic [3:0] r_count;
  logic       r_full;

  logic [0:8] w_occ;
  logic       w_legal;
  logic       w_last;

  // Legality is judged against the board as it stands, including the previous move
  always_comb begin
    w_occ   = r_p1 | r_p2;
    w_legal = 1'b0;
    if (move_pos <= 4'd8) begin
      w_legal = ~w_occ[move_pos];
    end else begin
      w_legal = 1'b0;
    end
    w_last = (r_count == 4'd8);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= FIRST_STATE;
      r_ready  <= 1'b1;
      r_accept <= 1'b0;
      r_reject <= 1'b0;
      r_p1     <= 9'b0;
      r_p2     <= 9'b0;
      r_turn   <= FIRST_TURN;
      r_count  <= 4'd0;
      r_full   <= 1'b0;
    end else if (clear) begin
      r_state  <= FIRST_STATE;
      r_ready  <= 1'b1;
      r_accept <= 1'b0;
      r_reject <= 1'b0;
      r_p1     <= 9'b0;
      r_p2     <= 9'b0;
      r_turn   <= FIRST_TURN;
      r_count  <= 4'd0;
      r_full   <= 1'b0;
    end else if (game_over) begin
      r_state  <= LOCKED;
      r_ready  <= 1'b0;
      r_accept <= 1'b0;
      r_reject <= 1'b0;
    end else if (move_valid && r_ready) begin
      if (w_legal) begin
        r_accept <= 1'b1;
        r_reject <= 1'b0;
        r_count  <= r_count + 4'd1;
        r_full   <= w_last;
        r_turn   <= ~r_turn;
        if (r_turn) begin
          r_p2[move_pos] <= 1'b1;
        end else begin
          r_p1[move_pos] <= 1'b1;
        end
        // The ninth accept locks the board when configured; otherwise turns keep alternating
        if (w_last && LOCK_FULL) begin
          r_state <= LOCKED;
          r_ready <= 1'b0;
        end else begin
          case (r_state)
            P1_TURN: r_state <= P2_TURN;
            P2_TURN: r_state <= P1_TURN;
            default: r_state <= LOCKED;
          endcase
        end
      end else begin
        r_accept <= 1'b0;
        r_reject <= 1'b1;
      end
    end else begin
      r_accept <= 1'b0;
      r_reject <= 1'b0;
    end
  end

  assign move_ready  = r_ready;
  assign move_accept = r_accept;
  assign move_reject = r_reject;
  assign p1          = r_p1;
  assign p2          = r_p2;
  assign turn        = r_turn;
  assign move_count  = r_count;
  assign board_full  = r_full;

endmodule
